// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its branch table.
package fetch_unit_pkg;

  localparam int PC_W_DEFAULT = 10;
  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch target table: registered write, combinational read, asynchronously cleared.
module branch_lut #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Each entry is its own flop bank so the whole table clears on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else if (we && (wr_addr == 5'(gi))) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/HALTED FSM, pc with branch mux, run-cycle counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEFAULT,
  parameter int unsigned START_ADDR = 0,
  parameter int          LUT_DEPTH  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic [8:0]      inst,
  input  logic            branch_en,
  input  logic            lut_we,
  input  logic [4:0]      lut_addr,
  input  logic [PC_W-1:0] lut_data,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic [15:0]     cycle_count
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cycle_count_q, cycle_count_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_target;
  logic            is_halt;

  branch_lut #(
    .DEPTH  (LUT_DEPTH),
    .DATA_W (PC_W)
  ) u_branch_lut (
    .clk     (clk),
    .reset   (reset),
    .we      (lut_we),
    .wr_addr (lut_addr),
    .wr_data (lut_data),
    .rd_addr (inst[4:0]),
    .rd_data (lut_target)
  );

  assign is_halt = (inst[8:5] == HALT_OPCODE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d       = ST_RUN;
          pc_d          = START_PC;
          cycle_count_d = '0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          cycle_count_d = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;
          // HALT parks pc on its own address and overrides any branch.
          if (is_halt) begin
            state_d = ST_HALTED;
          end else if (branch_en) begin
            pc_d = lut_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = START_PC;
      end
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= START_PC;
      cycle_count_q <= '0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cycle_count_q <= cycle_count_d;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign pc          = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  localparam logic [8:0] NOP = 9'h0C0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic [8:0]  inst;
  logic        branch_en;
  logic        lut_we;
  logic [4:0]  lut_addr;
  logic [9:0]  lut_data;
  logic [9:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .inst        (inst),
    .branch_en   (branch_en),
    .lut_we      (lut_we),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .pc          (pc),
    .running     (running),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; inst = NOP; branch_en = 1'b0;
    lut_we = 1'b0; lut_addr = '0; lut_data = '0;
    #3;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cc", 32'(cycle_count), 32'h0);
    tick(); tick();
    reset = 1'b0;

    lut_we = 1'b1; lut_addr = 5'd3; lut_data = 10'h155;
    tick();
    lut_we = 1'b0;
    check("idle_pc", 32'(pc), 32'h0);
    check("idle_running", 32'(running), 32'h0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_running", 32'(running), 32'h1);
    check("start_pc", 32'(pc), 32'h0);
    check("start_cc", 32'(cycle_count), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("seq_pc%0d", i), 32'(pc), 32'(i));
    end
    check("seq_cc", 32'(cycle_count), 32'd5);
    check("seq_running", 32'(running), 32'h1);

    inst = 9'h163; branch_en = 1'b1;
    tick();
    check("br_taken_pc", 32'(pc), 32'h155);
    check("br_taken_cc", 32'(cycle_count), 32'd6);
    branch_en = 1'b0;
    tick();
    check("br_not_taken_pc", 32'(pc), 32'h156);

    inst = NOP; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_pc", 32'(pc), 32'h157);
    check("start_in_run_cc", 32'(cycle_count), 32'd8);
    check("start_in_run_running", 32'(running), 32'h1);

    stall = 1'b1; inst = 9'h1E0; branch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_pc", i), 32'(pc), 32'h157);
      check($sformatf("stall%0d_cc", i), 32'(cycle_count), 32'd8);
      check($sformatf("stall%0d_running", i), 32'(running), 32'h1);
    end
    stall = 1'b0; branch_en = 1'b0;

    inst = NOP; lut_we = 1'b1; lut_addr = 5'd5; lut_data = 10'h3FF;
    tick();
    lut_we = 1'b0;
    check("run_write_pc", 32'(pc), 32'h158);
    check("run_write_cc", 32'(cycle_count), 32'd9);
    inst = 9'h165; branch_en = 1'b1;
    tick();
    check("to_3ff_pc", 32'(pc), 32'h3FF);
    inst = NOP; branch_en = 1'b0;
    tick();
    check("wrap_pc", 32'(pc), 32'h0);
    check("wrap_cc", 32'(cycle_count), 32'd11);

    inst = 9'h163; branch_en = 1'b1;
    lut_we = 1'b1; lut_addr = 5'd3; lut_data = 10'h200;
    tick();
    lut_we = 1'b0;
    check("same_cycle_old_target", 32'(pc), 32'h155);
    tick();
    check("next_new_target", 32'(pc), 32'h200);
    check("next_new_cc", 32'(cycle_count), 32'd13);

    inst = NOP; branch_en = 1'b0;
    lut_we = 1'b1; lut_addr = 5'd7; lut_data = 10'h007;
    tick();
    lut_we = 1'b0;
    check("pre_halt_pc_a", 32'(pc), 32'h201);
    inst = 9'h167; branch_en = 1'b1;
    tick();
    check("pre_halt_pc_b", 32'(pc), 32'h7);
    inst = 9'h1E0; branch_en = 1'b1;
    tick();
    check("halt_pc", 32'(pc), 32'h7);
    check("halt_done", 32'(done), 32'h1);
    check("halt_running", 32'(running), 32'h0);
    check("halt_cc", 32'(cycle_count), 32'd16);
    inst = NOP; branch_en = 1'b0;
    tick();
    check("halted_hold_pc", 32'(pc), 32'h7);
    check("halted_hold_cc", 32'(cycle_count), 32'd16);
    check("halted_hold_done", 32'(done), 32'h1);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_pc", 32'(pc), 32'h0);
    check("restart_running", 32'(running), 32'h1);
    check("restart_done", 32'(done), 32'h0);
    check("restart_cc", 32'(cycle_count), 32'h0);

    lut_we = 1'b1; lut_addr = 5'd9; lut_data = 10'h040;
    tick();
    lut_we = 1'b0;
    check("rerun_pc1", 32'(pc), 32'h1);
    inst = 9'h169; branch_en = 1'b1;
    tick();
    check("rerun_pc40", 32'(pc), 32'h40);
    inst = 9'h163; branch_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pc", 32'(pc), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_cc", 32'(cycle_count), 32'h0);
    check("async_rst_lut3", 32'(dut.lut_target), 32'h0);

    start = 1'b1; lut_we = 1'b1; lut_addr = 5'd3; lut_data = 10'h111;
    tick(); tick();
    start = 1'b0; lut_we = 1'b0;
    check("rst_held_running", 32'(running), 32'h0);
    check("rst_held_lut3", 32'(dut.lut_target), 32'h0);
    reset = 1'b0;
    tick(); tick();
    check("post_rst_running", 32'(running), 32'h0);
    check("post_rst_pc", 32'(pc), 32'h0);
    check("post_rst_done", 32'(done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
